ibex_irq_ctrl: RTL and testbench

- Parametrised interrupt-entry controller for the ibex pipeline; it replaces the fixed 15-line interrupt path in the core controller.
- Arbitrates NMI, NUM_FAST_IRQ fast lines and the three standard M-mode interrupts.
- Supports direct and vectored mtvec modes and tracks a bounded trap-nesting depth.
- Issues a PC redirect through a req/ack handshake towards the IF stage and pulses the CSR save strobe on acceptance.

---
 rtl/ibex_irq_ctrl_if.sv | 25 ++
 rtl/ibex_irq_ctrl.sv | 159 +++++++++++++++
 tb/tb_ibex_irq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_irq_ctrl_if.sv
// Redirect handshake between the interrupt-entry controller and the IF stage,
// carrying the handler PC, the mcause value and the CSR save strobe.
interface ibex_irq_ctrl_if;
    logic        redirect_req_o;
    logic        redirect_ack_i;
    logic [31:0] redirect_pc_o;
    logic [5:0]  exc_cause_o;
    logic        csr_save_o;

    modport master (
        output redirect_req_o,
        output redirect_pc_o,
        output exc_cause_o,
        output csr_save_o,
        input  redirect_ack_i
    );

    modport slave (
        input  redirect_req_o,
        input  redirect_pc_o,
        input  exc_cause_o,
        input  csr_save_o,
        output redirect_ack_i
    );
endinterface

// File: rtl/ibex_irq_ctrl.sv
// Interrupt-entry controller: arbitrates NMI, fast and standard M-mode lines,
// issues a PC redirect over a req/ack handshake and tracks trap nesting depth.
module ibex_irq_ctrl #(
    parameter  int unsigned NUM_FAST_IRQ = 15,
    parameter  int unsigned MAX_NEST     = 4,
    localparam int unsigned NW           = $clog2(MAX_NEST + 1)
) (
    input  logic                    CK,
    input  logic                    rst_i,
    input  logic [NUM_FAST_IRQ-1:0] irq_fast_i,
    input  logic                    irq_ext_i,
    input  logic                    irq_sw_i,
    input  logic                    irq_timer_i,
    input  logic                    irq_nm_i,
    input  logic                    mie_i,
    input  logic                    vectored_i,
    input  logic [31:0]             mtvec_base_i,
    input  logic                    stall_i,
    input  logic                    mret_i,
    input  logic                    debug_mode_i,
    ibex_irq_ctrl_if.master         redir,
    output logic                    nmi_mode_o,
    output logic [NW-1:0]           nest_depth_o,
    output logic                    nest_ovf_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REQ
    } state_e;

    localparam logic [5:0]    CauseNmi = 6'h3F;
    localparam logic [NW-1:0] DepthMax = NW'(MAX_NEST);

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [5:0]    cause_q, cause_d;
    logic          nmi_q, nmi_d;
    logic [NW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;

    logic          any_mask;
    logic          nmi_take;
    logic          mask_take;
    logic          take;
    logic [5:0]    arb_cause;
    logic [31:0]   arb_pc;
    logic          req;
    logic          save;
    logic          depth_inc;
    logic          depth_dec;

    assign any_mask  = (|irq_fast_i) | irq_ext_i | irq_sw_i | irq_timer_i;
    assign nmi_take  = irq_nm_i & ~nmi_q & ~debug_mode_i;
    assign mask_take = any_mask & mie_i & ~debug_mode_i & (depth_q < DepthMax);
    assign take      = nmi_take | mask_take;

    // Later assignments override earlier ones, so the list runs lowest to highest priority
    always_comb begin
        arb_cause = 6'h00;
        if (irq_timer_i) arb_cause = 6'h27;
        if (irq_sw_i)    arb_cause = 6'h23;
        if (irq_ext_i)   arb_cause = 6'h2B;
        for (int k = 0; k < int'(NUM_FAST_IRQ); k++) begin
            if (irq_fast_i[k]) arb_cause = {1'b1, 5'(16 + k)};
        end
        if (nmi_take)    arb_cause = CauseNmi;
    end

    assign arb_pc = (vectored_i && !nmi_take)
                  ? mtvec_base_i + {25'd0, arb_cause[4:0], 2'b00}
                  : mtvec_base_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        req     = 1'b0;
        save    = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (stall_i) begin
                        state_d = WAIT;
                    end else begin
                        pc_d    = arb_pc;
                        cause_d = arb_cause;
                        state_d = REQ;
                    end
                end
            end
            // Arbitration is redone on release so a late NMI wins and a withdrawn line is dropped
            WAIT: begin
                if (!stall_i) begin
                    if (take) begin
                        pc_d    = arb_pc;
                        cause_d = arb_cause;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REQ: begin
                req = 1'b1;
                if (redir.redirect_ack_i) begin
                    save    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An ack that would push past the ceiling is recorded as a sticky overflow instead
    always_comb begin
        depth_inc = save;
        depth_dec = mret_i && (depth_q != '0);
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        nmi_d     = nmi_q;
        if (depth_inc && !depth_dec) begin
            if (depth_q == DepthMax) ovf_d = 1'b1;
            else                     depth_d = depth_q + NW'(1);
        end else if (!depth_inc && depth_dec) begin
            depth_d = depth_q - NW'(1);
        end
        if (save && (cause_q == CauseNmi)) nmi_d = 1'b1;
        else if (mret_i)                   nmi_d = 1'b0;
    end

    always_ff @(posedge CK or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            nmi_q   <= 1'b0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            nmi_q   <= nmi_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
        end
    end

    assign redir.redirect_req_o = req;
    assign redir.csr_save_o     = save;
    assign redir.redirect_pc_o  = pc_q;
    assign redir.exc_cause_o    = cause_q;
    assign nmi_mode_o           = nmi_q;
    assign nest_depth_o         = depth_q;
    assign nest_ovf_o           = ovf_q;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Scoreboard bench for ibex_irq_ctrl: stimulus queues expected redirects,
// a negedge monitor pops and compares them on every CSR save strobe.
module tb_ibex_irq_ctrl;

    localparam int unsigned NFAST = 15;
    localparam int unsigned NEST  = 2;
    localparam int unsigned NW    = $clog2(NEST + 1);

    typedef struct {
        logic [5:0]  cause;
        logic [31:0] pc;
    } exp_t;

    logic             CK;
    logic             rst_i;
    logic [NFAST-1:0] irq_fast_i;
    logic             irq_ext_i;
    logic             irq_sw_i;
    logic             irq_timer_i;
    logic             irq_nm_i;
    logic             mie_i;
    logic             vectored_i;
    logic [31:0]      mtvec_base_i;
    logic             stall_i;
    logic             mret_i;
    logic             debug_mode_i;
    logic             nmi_mode_o;
    logic [NW-1:0]    nest_depth_o;
    logic             nest_ovf_o;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    ibex_irq_ctrl_if ifc ();

    ibex_irq_ctrl #(
        .NUM_FAST_IRQ (NFAST),
        .MAX_NEST     (NEST)
    ) dut (
        .CK           (CK),
        .rst_i        (rst_i),
        .irq_fast_i   (irq_fast_i),
        .irq_ext_i    (irq_ext_i),
        .irq_sw_i     (irq_sw_i),
        .irq_timer_i  (irq_timer_i),
        .irq_nm_i     (irq_nm_i),
        .mie_i        (mie_i),
        .vectored_i   (vectored_i),
        .mtvec_base_i (mtvec_base_i),
        .stall_i      (stall_i),
        .mret_i       (mret_i),
        .debug_mode_i (debug_mode_i),
        .redir        (ifc.master),
        .nmi_mode_o   (nmi_mode_o),
        .nest_depth_o (nest_depth_o),
        .nest_ovf_o   (nest_ovf_o)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"},   32'(ifc.redirect_req_o), 32'd0);
        checkOutput({tag, "_pc"},    ifc.redirect_pc_o,       32'd0);
        checkOutput({tag, "_cause"}, 32'(ifc.exc_cause_o),    32'd0);
        checkOutput({tag, "_save"},  32'(ifc.csr_save_o),     32'd0);
        checkOutput({tag, "_nmi"},   32'(nmi_mode_o),         32'd0);
        checkOutput({tag, "_depth"}, 32'(nest_depth_o),       32'd0);
        checkOutput({tag, "_ovf"},   32'(nest_ovf_o),         32'd0);
    endtask

    task automatic applyStimulus(input logic [NFAST-1:0] fast, input logic ext, input logic sw,
                                 input logic timer, input logic nm);
        irq_fast_i  = fast;
        irq_ext_i   = ext;
        irq_sw_i    = sw;
        irq_timer_i = timer;
        irq_nm_i    = nm;
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic pushExp(input logic [5:0] cause, input logic [31:0] pc);
        exp_t e;
        e.cause = cause;
        e.pc    = pc;
        expQ.push_back(e);
    endtask

    task automatic waitReq(input int maxCycles);
        int n = 0;
        while (!ifc.redirect_req_o && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("req_seen", 32'(ifc.redirect_req_o), 32'd1);
    endtask

    task automatic ackRedirect();
        waitReq(20);
        ifc.redirect_ack_i = 1'b1;
        tick();
        ifc.redirect_ack_i = 1'b0;
    endtask

    task automatic mretPulse();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    // Every CSR save strobe must match the oldest outstanding expectation
    always @(negedge CK) begin
        if (!rst_i && ifc.csr_save_o) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_redirect got cause=%h pc=%h want=none",
                         ifc.exc_cause_o, ifc.redirect_pc_o);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_cause", 32'(ifc.exc_cause_o), 32'(e.cause));
                checkOutput("sb_pc",    ifc.redirect_pc_o,    e.pc);
            end
        end
    end

    initial begin
        rst_i              = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        mie_i              = 1'b0;
        vectored_i         = 1'b0;
        mtvec_base_i       = 32'h0;
        stall_i            = 1'b0;
        mret_i             = 1'b0;
        debug_mode_i       = 1'b0;
        ifc.redirect_ack_i = 1'b0;
        #12;
        checkAllZero("reset");
        @(posedge CK);
        #1;
        rst_i = 1'b0;
        tick();

        // Fast bit 4 outranks fast bit 1 and ext: cause 0x34, pc 0x1000 + 20*4
        mie_i        = 1'b1;
        vectored_i   = 1'b1;
        mtvec_base_i = 32'h0000_1000;
        applyStimulus(15'h0012, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(6'h34, 32'h0000_1050);
        tick();
        checkOutput("t1_latency_req", 32'(ifc.redirect_req_o), 32'd1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        ackRedirect();
        checkOutput("t1_depth",   32'(nest_depth_o),       32'd1);
        checkOutput("t1_req_low", 32'(ifc.redirect_req_o), 32'd0);
        mretPulse();
        checkOutput("t1_mret_depth", 32'(nest_depth_o), 32'd0);

        // NMI is never vectored and blocks a second NMI until mret
        mie_i        = 1'b0;
        mtvec_base_i = 32'h0000_2000;
        applyStimulus(15'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        pushExp(6'h3F, 32'h0000_2000);
        tick();
        checkOutput("t2_req", 32'(ifc.redirect_req_o), 32'd1);
        ackRedirect();
        checkOutput("t2_nmi_mode", 32'(nmi_mode_o),   32'd1);
        checkOutput("t2_depth",    32'(nest_depth_o), 32'd1);
        repeat (3) tick();
        checkOutput("t2_no_second_nmi", 32'(ifc.redirect_req_o), 32'd0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        mretPulse();
        checkOutput("t2_nmi_cleared", 32'(nmi_mode_o),   32'd0);
        checkOutput("t2_depth_zero",  32'(nest_depth_o), 32'd0);

        // Stalled timer withdrawn before release produces no redirect
        mie_i        = 1'b1;
        vectored_i   = 1'b1;
        mtvec_base_i = 32'h0000_3000;
        stall_i      = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("t3_stalled_req", 32'(ifc.redirect_req_o), 32'd0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        stall_i = 1'b0;
        tick();
        tick();
        checkOutput("t3_withdrawn_req",   32'(ifc.redirect_req_o), 32'd0);
        checkOutput("t3_withdrawn_depth", 32'(nest_depth_o),       32'd0);

        // Software line held through the stall: redirect one cycle after release
        stall_i = 1'b1;
        applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        checkOutput("t3_sw_stalled", 32'(ifc.redirect_req_o), 32'd0);
        pushExp(6'h23, 32'h0000_300C);
        stall_i = 1'b0;
        tick();
        checkOutput("t3_sw_req", 32'(ifc.redirect_req_o), 32'd1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        ackRedirect();
        checkOutput("t3_sw_depth", 32'(nest_depth_o), 32'd1);
        mretPulse();

        // Nesting ceiling of 2: third ext ignored, NMI overflows, ack+mret holds depth
        vectored_i   = 1'b0;
        mtvec_base_i = 32'h0000_4000;
        applyStimulus('0, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(6'h2B, 32'h0000_4000);
        pushExp(6'h2B, 32'h0000_4000);
        ackRedirect();
        checkOutput("t4_depth1", 32'(nest_depth_o), 32'd1);
        ackRedirect();
        checkOutput("t4_depth2", 32'(nest_depth_o), 32'd2);
        repeat (3) tick();
        checkOutput("t4_third_ignored", 32'(ifc.redirect_req_o), 32'd0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
        pushExp(6'h3F, 32'h0000_4000);
        ackRedirect();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_ovf_depth", 32'(nest_depth_o), 32'd2);
        checkOutput("t4_ovf",       32'(nest_ovf_o),   32'd1);
        checkOutput("t4_nmi_mode",  32'(nmi_mode_o),   32'd1);
        mretPulse();
        checkOutput("t4_mret_depth", 32'(nest_depth_o), 32'd1);
        checkOutput("t4_mret_nmi",   32'(nmi_mode_o),   32'd0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(6'h2B, 32'h0000_4000);
        waitReq(20);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        ifc.redirect_ack_i = 1'b1;
        mret_i             = 1'b1;
        tick();
        ifc.redirect_ack_i = 1'b0;
        mret_i             = 1'b0;
        checkOutput("t4_ackmret_depth", 32'(nest_depth_o), 32'd1);
        checkOutput("t4_ovf_sticky",    32'(nest_ovf_o),   32'd1);

        // Request held without ack: latched cause/pc ignore input churn
        vectored_i   = 1'b1;
        mtvec_base_i = 32'h0000_5000;
        applyStimulus(15'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t5_req", 32'(ifc.redirect_req_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(NFAST'(16'h1357 * (i + 1)), i[0], i[1], i[2], i[0]);
            vectored_i   = ~i[0];
            mtvec_base_i = 32'h0000_A000 + 32'(i) * 32'h100;
            tick();
            checkOutput("t5_hold_cause", 32'(ifc.exc_cause_o), 32'h30);
            checkOutput("t5_hold_pc",    ifc.redirect_pc_o,    32'h0000_5040);
        end
        rst_i = 1'b1;
        #1;
        checkAllZero("t5_async_rst");
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();
        checkOutput("t5_idle_after_rst", 32'(ifc.redirect_req_o), 32'd0);

        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
